dnoc_itf_in_c_channel: RTL
==========================

DNOC_ITF_IN_C_CHANNEL -- requirements
Module: dnoc_itf_in_c_channel

Interface
REQ-001 SHALL have parameter NODE_ID, default 4'd0, meaning the node id compared against head flit bits [3:0].
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk input 1 clock; rst_n input 1 reset.
REQ-003 SHALL have ports: out_flit input 256 NoC head flit; out_last input 1 last flit; out_valid input 1; out_ready output 1.
REQ-004 SHALL have ports: rd_req_valid output 1; rd_req_ready input 1, for read requests (flit[4]=0).
REQ-005 SHALL have ports: core_rsp_valid output 1 and core_rsp_ready input 1 (flit[4]=1, flit[5]=0); dma_rsp_valid output 1 and dma_rsp_ready input 1 (flit[4]=1, flit[5]=1).
REQ-006 SHALL have head-entry field outputs:
- hd_src_id 12 [18:7]
- hd_mc 1 [6]
- hd_req_from_dma 1 [5]
- hd_access_mode 1 [254]
- hd_loop_lenth 52 [198:147]
- hd_loop_gap 52 [146:95]
- hd_pong_lenth 13 [94:82]
- hd_ping_lenth 13 [81:69]
- hd_pingpong_num 11 [68:58]
- hd_pingpong_en 1 [57]
- hd_base_addr1 13 [56:44]
- hd_base_addr 25 [43:19]
REQ-007 SHALL have ports: err_cnt output 8 dropped-flit count; err_clr input 1 synchronous clear.

Function
REQ-008 SHALL hold a 2-entry FIFO of accepted flits; occupancy cnt 0..2; wr/rd pointers wrap 1->0.
REQ-009 SHALL drive out_ready = (cnt != 2), decoded from registered cnt only, with no combinational path from any consumer ready.
REQ-010 SHALL accept a flit on clk edge when out_valid & out_ready.
REQ-011 SHALL classify an accepted flit as good when out_last=1 and (flit[3:0]==NODE_ID or flit[6]=1); only good flits are enqueued.
REQ-012 SHALL still accept (consume) a non-good flit but drop it, not enqueue it, and increment err_cnt.
REQ-013 SHALL saturate err_cnt at 255; err_clr sets it to 0, and err_clr wins over a simultaneous drop event.
REQ-014 SHALL present the head entry one cycle after enqueue, with no same-cycle bypass: a flit accepted at edge N is visible after edge N.
REQ-015 SHALL assert exactly one of rd_req_valid, core_rsp_valid or dma_rsp_valid when cnt>0, selected by head [4] and [5]; all three are 0 when cnt=0.
REQ-016 SHALL pop the head on the edge where the selected valid and its matching ready are both 1; readies of unselected channels are ignored.
REQ-017 SHALL hold the valid and all hd_* outputs stable while valid=1 and ready=0.
REQ-018 SHALL drive hd_* to 0 when cnt=0.
REQ-019 SHALL handle simultaneous push and pop at cnt=1: cnt stays 1, and the new flit becomes head on the next edge.
REQ-020 SHALL handle a pop at cnt=2 with no push possible (out_ready=0): cnt becomes 1.
REQ-021 SHALL NOT change cnt on an accepted dropped flit with a simultaneous pop; cnt decrements by the pop only.
REQ-022 SHALL deliver strictly in arrival order; a blocked head blocks later entries regardless of class.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously set cnt=0, pointers=0 and err_cnt=0; consequently out_ready=1, all channel valids=0 and hd_*=0.
REQ-024 SHALL discard FIFO contents on reset asserted mid-operation; no valid is asserted on the first cycle after release.

Verification
REQ-025 Push a rd req with [3:0]=NODE_ID, [18:7]=12'h005, [43:19]=25'h0001234, last=1, rd_req_ready=1 -> rd_req_valid=1 for 1 cycle, one cycle after acceptance, hd_src_id=5, hd_base_addr=0x1234.
REQ-026 Hold all readies=0 and push 3 good flits back-to-back -> 2 accepted, out_ready=0 after the second, third held; raise core_rsp_ready -> entries drain in order.
REQ-027 Push a flit with [3:0]=NODE_ID+1 and [6]=0, then one with last=0 -> both consumed, no valid asserted, err_cnt=2; same-cycle err_clr with a drop -> err_cnt=0.
REQ-028 Push a response with [4]=1, [5]=1 while dma_rsp_ready=0 and core_rsp_ready=1 -> dma_rsp_valid stays 1 with hd_* stable, core_rsp_valid=0, no pop until dma_rsp_ready=1.
REQ-029 Stream 300 misrouted flits -> err_cnt saturates at 255.
REQ-030 Fill FIFO to cnt=2, assert rst_n=0 for 1 cycle -> out_ready=1, all valids=0, err_cnt=0; a push after release is delivered normally.

Source files
------------

// File: rtl/dnoc_itf_in_c_channel.sv
`default_nettype none
// ============================================================================
//  Module      : dnoc_itf_in_c_channel
//  Description : NoC ingress channel for one node. Consumes NoC flits,
//                enqueues the ones addressed to this node (or multicast) in
//                a 2-entry FIFO, counts dropped flits, and steers the head
//                entry to one of three consumers: read requests, core
//                responses or DMA responses. The head entry's fields are
//                decoded onto the hd_* outputs.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                out_flit/last/valid   - incoming NoC flit (ready: out_ready)
//                rd_req_valid/ready    - read request channel (flit[4]=0)
//                core_rsp_valid/ready  - core response (flit[4]=1, [5]=0)
//                dma_rsp_valid/ready   - DMA response (flit[4]=1, [5]=1)
//                hd_*                  - head entry fields, 0 when empty
//                err_cnt, err_clr      - saturating dropped-flit counter
//  Revision    : 1.0 - initial release
// ============================================================================
module dnoc_itf_in_c_channel #(
    parameter logic [3:0] NODE_ID = 4'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] out_flit,
    input  logic         out_last,
    input  logic         out_valid,
    output logic         out_ready,
    output logic         rd_req_valid,
    input  logic         rd_req_ready,
    output logic         core_rsp_valid,
    input  logic         core_rsp_ready,
    output logic         dma_rsp_valid,
    input  logic         dma_rsp_ready,
    output logic [11:0]  hd_src_id,
    output logic         hd_mc,
    output logic         hd_req_from_dma,
    output logic         hd_access_mode,
    output logic [51:0]  hd_loop_lenth,
    output logic [51:0]  hd_loop_gap,
    output logic [12:0]  hd_pong_lenth,
    output logic [12:0]  hd_ping_lenth,
    output logic [10:0]  hd_pingpong_num,
    output logic         hd_pingpong_en,
    output logic [12:0]  hd_base_addr1,
    output logic [24:0]  hd_base_addr,
    output logic [7:0]   err_cnt,
    input  logic         err_clr
);

    // Only flit bits [254] and [198:4] are ever presented, so an entry
    // stores just those: entry[195] = flit[254], entry[194:0] = flit[198:4].
    // c_OFS maps a flit bit position onto the entry.
    localparam int          c_OFS   = 4;
    localparam int          c_EW    = 196;
    localparam logic [1:0]  c_FULL  = 2'd2;
    localparam logic [7:0]  c_ERR_MAX = 8'hFF;

    logic [c_EW-1:0] mem_q [2];
    logic [1:0]      cnt_q, cnt_d;
    logic            wr_ptr_q, rd_ptr_q;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            w_accept, w_good, w_push, w_drop, w_pop, w_nonempty;
    logic [c_EW-1:0] w_entry, w_head;
    logic            w_unused_bits;

    // Destination bits are only used for the accept decision; the rest of
    // the unused flit bits are never presented.
    assign w_unused_bits = ^{out_flit[255], out_flit[253:199], out_flit[3:0]};

    // Ready depends on registered occupancy only: no path from consumers.
    assign out_ready = (cnt_q != c_FULL);

    assign w_accept = out_valid & out_ready;
    assign w_good   = out_last & ((out_flit[3:0] == NODE_ID) | out_flit[6]);
    assign w_push   = w_accept & w_good;
    assign w_drop   = w_accept & ~w_good;
    assign w_entry  = {out_flit[254], out_flit[198:4]};

    assign w_nonempty = (cnt_q != 2'd0);
    assign w_head     = w_nonempty ? mem_q[rd_ptr_q] : '0;

    // Class select from the head entry; all zero when empty since w_head
    // is forced to zero and the nonempty term gates the rd channel.
    assign rd_req_valid   = w_nonempty & ~w_head[4-c_OFS];
    assign core_rsp_valid = w_nonempty &  w_head[4-c_OFS] & ~w_head[5-c_OFS];
    assign dma_rsp_valid  = w_nonempty &  w_head[4-c_OFS] &  w_head[5-c_OFS];

    assign w_pop = (rd_req_valid   & rd_req_ready)
                 | (core_rsp_valid & core_rsp_ready)
                 | (dma_rsp_valid  & dma_rsp_ready);

    assign hd_src_id       = w_head[18-c_OFS:7-c_OFS];
    assign hd_mc           = w_head[6-c_OFS];
    assign hd_req_from_dma = w_head[5-c_OFS];
    assign hd_access_mode  = w_head[c_EW-1];
    assign hd_loop_lenth   = w_head[198-c_OFS:147-c_OFS];
    assign hd_loop_gap     = w_head[146-c_OFS:95-c_OFS];
    assign hd_pong_lenth   = w_head[94-c_OFS:82-c_OFS];
    assign hd_ping_lenth   = w_head[81-c_OFS:69-c_OFS];
    assign hd_pingpong_num = w_head[68-c_OFS:58-c_OFS];
    assign hd_pingpong_en  = w_head[57-c_OFS];
    assign hd_base_addr1   = w_head[56-c_OFS:44-c_OFS];
    assign hd_base_addr    = w_head[43-c_OFS:19-c_OFS];

    assign err_cnt = err_cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Clear has priority over a drop in the same cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = 8'd0;
        end else if (w_drop && (err_cnt_q != c_ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
            if (w_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Storage needs no reset: contents are masked while cnt is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

endmodule
`default_nettype wire
